// File: rtl/sort_gather_pkg.sv
// Shared constants and helpers for the four-element gatherer that feeds the sorter.
package sort_gather_pkg;

    localparam int GATHER_NELMS        = 4;
    localparam int GATHER_IDX_NBITS    = 2;
    localparam int GATHER_NVALID_NBITS = 3;
    localparam int GATHER_PAD_MAX_NBITS = 64;

    // Pad elements are all-ones so they always sort to the high end of the bundle.
    function automatic logic [GATHER_PAD_MAX_NBITS-1:0] pad_value(input int nbits);
        logic [GATHER_PAD_MAX_NBITS-1:0] r;
        r = '0;
        for (int i = 0; i < GATHER_PAD_MAX_NBITS; i++) begin
            r[i] = (i < nbits);
        end
        return r;
    endfunction

endpackage

// File: rtl/sort_gather_unit.sv
// Packs four serially accepted elements into one registered bundle for the sorter.
// Optional early completion with all-ones padding is compiled in by SORT_GATHER_PAD_EN.
module sort_gather_unit
    import sort_gather_pkg::*;
#(
    parameter int p_nbits = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_val,
    output logic                           in_rdy,
    input  logic [p_nbits-1:0]             in_msg,
    input  logic                           in_last,
    output logic                           out_val,
    output logic [p_nbits-1:0]             out0,
    output logic [p_nbits-1:0]             out1,
    output logic [p_nbits-1:0]             out2,
    output logic [p_nbits-1:0]             out3,
    output logic [GATHER_NVALID_NBITS-1:0] out_nvalid
);

    localparam logic [GATHER_IDX_NBITS-1:0] IDX_LAST = GATHER_IDX_NBITS'(GATHER_NELMS - 1);

    logic [GATHER_IDX_NBITS-1:0] idx;
    logic [p_nbits-1:0]          slot        [GATHER_NELMS];
    logic [p_nbits-1:0]          next_bundle [GATHER_NELMS];
    logic [p_nbits-1:0]          pad;
    logic                        accept;
    logic                        complete;

    assign in_rdy = ~reset;
    assign accept = in_val & in_rdy;
    assign pad    = p_nbits'(pad_value(p_nbits));

`ifdef SORT_GATHER_PAD_EN
    assign complete = accept & ((idx == IDX_LAST) | in_last);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign complete = accept & (idx == IDX_LAST);
`endif

    // Earlier slots, then the element arriving now, then padding for anything past it.
    always_comb begin
        for (int j = 0; j < GATHER_NELMS; j++) begin
            next_bundle[j] = pad;
            if (GATHER_IDX_NBITS'(j) < idx) begin
                next_bundle[j] = slot[j];
            end else if (GATHER_IDX_NBITS'(j) == idx) begin
                next_bundle[j] = in_msg;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            out_val    <= 1'b0;
            out0       <= '0;
            out1       <= '0;
            out2       <= '0;
            out3       <= '0;
            out_nvalid <= '0;
            for (int j = 0; j < GATHER_NELMS; j++) begin
                slot[j] <= '0;
            end
        end else begin
            out_val <= complete;
            if (accept) begin
                slot[idx] <= in_msg;
                if (complete) begin
                    idx        <= '0;
                    out0       <= next_bundle[0];
                    out1       <= next_bundle[1];
                    out2       <= next_bundle[2];
                    out3       <= next_bundle[3];
                    out_nvalid <= GATHER_NVALID_NBITS'(idx) + GATHER_NVALID_NBITS'(1);
                end else begin
                    idx <= idx + GATHER_IDX_NBITS'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    function automatic string line_trace();
        return $sformatf("%s%h idx=%0d | %s%h %h %h %h n=%0d",
                         accept ? "+" : " ", in_msg, idx,
                         out_val ? "*" : " ", out0, out1, out2, out3, out_nvalid);
    endfunction
`endif

endmodule
